int_sequencer: RTL and testbench
================================

# int_sequencer

Interrupt/reset sequencer for the 6502 core's register datapath. It arbitrates between RESET, NMI, BRK and IRQ at instruction boundaries. It then runs the 7-cycle service sequence: stack pushes of PCH/PCL/P through the stack pointer register, and vector fetch into the program-counter registers. It produces the load/bus-enable strobes for S, PCL and PCH and the vector address. It never touches ALU or accumulator paths.

## Interface
No parameters; vector addresses are fixed (NMI FFFA, RESET FFFC, IRQ/BRK FFFE).
- CLK  in  1  core clock; all state changes on rising edge
- RES_N  in  1  asynchronous, active-low reset; release schedules a RESET sequence
- RDY  in  1  1 = advance; 0 = hold current step, all outputs frozen
- INSTR_END  in  1  1 = current cycle is last cycle of an instruction (arbitration point)
- BRK_REQ  in  1  decoder flags BRK opcode; sampled only with INSTR_END
- NMI_N  in  1  NMI pin, falling-edge sensitive
- IRQ_N  in  1  IRQ pin, level-sensitive, masked by I_FLAG
- I_FLAG  in  1  interrupt-disable flag from P
- SEQ_BUSY  out  1  sequence in progress (T0..T6)
- SEQ_STEP  out  3  current step 0..6; 0 when idle
- SEQ_KIND  out  2  0 RESET, 1 NMI, 2 BRK, 3 IRQ; held after DONE until next start
- RW  out  1  1 read, 0 write
- S_ADL_BUS_ENABLE  out  1  stack pointer drives ADL
- S_DEC  out  1  decrement S at end of step
- DB_SRC  out  2  0 none, 1 PCH, 2 PCL, 3 P
- PUSH_B  out  1  B bit value for pushed P
- VEC_ADDR  out  16  vector fetch address
- PCL_LOAD, PCH_LOAD  out  1 each  load PC byte from DB
- SET_I  out  1  set I flag
- DONE  out  1  one-cycle pulse in T6

## Operation
- Reset (RES_N low): all outputs 0 except RW=1; SEQ_KIND=0. Internal state: idle, nmi_prev=1, nmi_pending=0, reset_pending=1.
- NMI edge detect: nmi_prev<=NMI_N each clock. nmi_prev=1 && NMI_N=0 sets nmi_pending, including while busy or RDY=0.
- Idle arbitration, evaluated each clock with RDY=1. Priority: reset_pending > nmi_pending > BRK_REQ > (!IRQ_N && !I_FLAG).
  - reset_pending starts unconditionally.
  - All other triggers require INSTR_END=1.
  - Winner latched into SEQ_KIND; T0 is entered on the next edge.
- Steps, each lasting one RDY=1 cycle:
  - T0, T1: internal, RW=1, no strobes.
  - T2: S_ADL_BUS_ENABLE=1, DB_SRC=1, S_DEC=1, RW=0.
  - T3: as T2 but DB_SRC=2.
  - T4: as T2 but DB_SRC=3; PUSH_B=1 only for BRK; SET_I=1.
  - T5: VEC_ADDR=vector low, PCL_LOAD=1, RW=1.
  - T6: VEC_ADDR=vector+1, PCH_LOAD=1, DONE=1; return to idle on the next edge.
- RESET kind: T2–T4 keep RW=1 and DB_SRC=0. S_DEC still pulses (dummy pushes). SET_I=1 in T4.
- Vector selection at T5 entry:
  - RESET→FFFC.
  - NMI→FFFA.
  - BRK/IRQ→FFFE, unless nmi_pending=1 at the T4→T5 edge (NMI hijack). In that case use FFFA and set SEQ_KIND=1; PUSH_B keeps the value already pushed.
- nmi_pending clears on the T4→T5 edge of any sequence using FFFA. reset_pending clears on entry to T0.
- IRQ is not latched. If IRQ_N deasserts before arbitration, nothing starts. IRQ activity during a sequence is ignored.
- BRK_REQ without INSTR_END is ignored.

## Timing
- Latency: trigger sampled at edge N; T0 in cycle N+1; DONE in cycle N+7. The earliest next arbitration is the first cycle after T6.
- After RES_N release, T0 begins on the first rising edge and DONE arrives 7 cycles later, with RDY=1.
- RDY=0 inserts wait cycles. Step, outputs and latched kind hold; NMI edge detection continues.
- RES_N assertion mid-sequence aborts immediately (async). After release, a full RESET sequence runs.
- An NMI edge arriving after the T4→T5 edge of an NMI or hijacked sequence stays pending. It is serviced at the first arbitration after DONE, without INSTR_END.
- An NMI held low does not retrigger; a new falling edge is required.

## Test plan
- Release RES_N, RDY=1 → SEQ_STEP 0..6 over 7 cycles; RW stays 1; S_DEC high in T2–T4; VEC_ADDR FFFC then FFFD; DONE in cycle 7.
- IRQ_N=0, I_FLAG=0, INSTR_END pulse → DB_SRC 1,2,3 with RW=0 in T2–T4; PUSH_B=0; VEC_ADDR FFFE/FFFF. Repeat with I_FLAG=1 → no sequence.
- BRK_REQ+INSTR_END together with IRQ_N=0 → SEQ_KIND=2, PUSH_B=1 in T4.
- BRK started, NMI falling edge during T3 → T5 VEC_ADDR=FFFA; SEQ_KIND=1; PUSH_B was 1; nmi_pending cleared, with no second NMI after DONE.
- RDY=0 for 3 cycles during T2 → T2 strobes held 4 cycles; S_DEC takes effect once; DONE delayed by 3.
- RES_N low during T4 of IRQ → outputs go to reset values at once; after release, a RESET sequence runs to DONE with VEC_ADDR FFFC.

Source files
------------

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer: arbitrates RESET/NMI/BRK/IRQ at instruction boundaries and
// drives the 7-step push/vector-fetch service sequence for the S and PC registers.
module int_sequencer (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        RDY,
    input  logic        INSTR_END,
    input  logic        BRK_REQ,
    input  logic        NMI_N,
    input  logic        IRQ_N,
    input  logic        I_FLAG,
    output logic        SEQ_BUSY,
    output logic [2:0]  SEQ_STEP,
    output logic [1:0]  SEQ_KIND,
    output logic        RW,
    output logic        S_ADL_BUS_ENABLE,
    output logic        S_DEC,
    output logic [1:0]  DB_SRC,
    output logic        PUSH_B,
    output logic [15:0] VEC_ADDR,
    output logic        PCL_LOAD,
    output logic        PCH_LOAD,
    output logic        SET_I,
    output logic        DONE
);

    localparam int unsigned STEP_W = 3;
    localparam int unsigned KIND_W = 2;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned ADDR_W = 16;

    localparam logic [KIND_W-1:0] KIND_RESET = KIND_W'(0);
    localparam logic [KIND_W-1:0] KIND_NMI   = KIND_W'(1);
    localparam logic [KIND_W-1:0] KIND_BRK   = KIND_W'(2);
    localparam logic [KIND_W-1:0] KIND_IRQ   = KIND_W'(3);

    localparam logic [STEP_W-1:0] STEP_T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(6);

    localparam logic [ADDR_W-1:0] VEC_NMI   = ADDR_W'(16'hFFFA);
    localparam logic [ADDR_W-1:0] VEC_RESET = ADDR_W'(16'hFFFC);
    localparam logic [ADDR_W-1:0] VEC_IRQ   = ADDR_W'(16'hFFFE);

    // sequencer state
    logic                busy_q, busy_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [KIND_W-1:0]   kind_q, kind_d;
    logic                nmi_prev_q;
    logic                nmi_pending_q, nmi_pending_d;
    logic                reset_pending_q, reset_pending_d;
    logic                after_done_q, after_done_d;
    logic                nmi_edge;
    logic                nmi_clr;

    // registered strobes
    logic                rw_q, rw_d;
    logic                s_adl_q, s_adl_d;
    logic                s_dec_q, s_dec_d;
    logic [SRC_W-1:0]    db_src_q, db_src_d;
    logic                push_b_q, push_b_d;
    logic [ADDR_W-1:0]   vec_addr_q, vec_addr_d;
    logic                pcl_load_q, pcl_load_d;
    logic                pch_load_q, pch_load_d;
    logic                set_i_q, set_i_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   vec_base;

    assign nmi_edge = nmi_prev_q & ~NMI_N;

    // state register (outputs are registered alongside so they track the new step)
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            busy_q          <= 1'b0;
            step_q          <= '0;
            kind_q          <= KIND_RESET;
            nmi_prev_q      <= 1'b1;
            nmi_pending_q   <= 1'b0;
            reset_pending_q <= 1'b1;
            after_done_q    <= 1'b0;
            rw_q            <= 1'b1;
            s_adl_q         <= 1'b0;
            s_dec_q         <= 1'b0;
            db_src_q        <= '0;
            push_b_q        <= 1'b0;
            vec_addr_q      <= '0;
            pcl_load_q      <= 1'b0;
            pch_load_q      <= 1'b0;
            set_i_q         <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            step_q          <= step_d;
            kind_q          <= kind_d;
            nmi_prev_q      <= NMI_N;
            nmi_pending_q   <= nmi_pending_d;
            reset_pending_q <= reset_pending_d;
            after_done_q    <= after_done_d;
            rw_q            <= rw_d;
            s_adl_q         <= s_adl_d;
            s_dec_q         <= s_dec_d;
            db_src_q        <= db_src_d;
            push_b_q        <= push_b_d;
            vec_addr_q      <= vec_addr_d;
            pcl_load_q      <= pcl_load_d;
            pch_load_q      <= pch_load_d;
            set_i_q         <= set_i_d;
            done_q          <= done_d;
        end
    end

    // next state: arbitration when idle, step advance and NMI hijack when busy
    always_comb begin
        busy_d          = busy_q;
        step_d          = step_q;
        kind_d          = kind_q;
        reset_pending_d = reset_pending_q;
        after_done_d    = after_done_q;
        nmi_clr         = 1'b0;
        if (RDY) begin
            if (!busy_q) begin
                after_done_d = 1'b0;
                if (reset_pending_q) begin
                    busy_d          = 1'b1;
                    step_d          = '0;
                    kind_d          = KIND_RESET;
                    reset_pending_d = 1'b0;
                end else if (nmi_pending_q && (INSTR_END || after_done_q)) begin
                    busy_d = 1'b1;
                    step_d = '0;
                    kind_d = KIND_NMI;
                end else if (INSTR_END && BRK_REQ) begin
                    busy_d = 1'b1;
                    step_d = '0;
                    kind_d = KIND_BRK;
                end else if (INSTR_END && !IRQ_N && !I_FLAG) begin
                    busy_d = 1'b1;
                    step_d = '0;
                    kind_d = KIND_IRQ;
                end
            end else if (step_q == STEP_LAST) begin
                busy_d       = 1'b0;
                step_d       = '0;
                after_done_d = 1'b1;
            end else begin
                step_d = step_q + STEP_W'(1);
                // a pending NMI steals the vector of a BRK/IRQ before its fetch begins
                if (step_q == STEP_T4 &&
                    (kind_q == KIND_NMI || (kind_q[1] && nmi_pending_q))) begin
                    kind_d  = KIND_NMI;
                    nmi_clr = 1'b1;
                end
            end
        end
        nmi_pending_d = (nmi_pending_q & ~nmi_clr) | nmi_edge;
    end

    always_comb begin
        case (kind_d)
            KIND_RESET: vec_base = VEC_RESET;
            KIND_NMI:   vec_base = VEC_NMI;
            default:    vec_base = VEC_IRQ;
        endcase
    end

    // output decode of the step about to be entered
    always_comb begin
        rw_d       = 1'b1;
        s_adl_d    = 1'b0;
        s_dec_d    = 1'b0;
        db_src_d   = '0;
        push_b_d   = 1'b0;
        vec_addr_d = '0;
        pcl_load_d = 1'b0;
        pch_load_d = 1'b0;
        set_i_d    = 1'b0;
        done_d     = 1'b0;
        if (busy_d) begin
            case (step_d)
                STEP_W'(2), STEP_W'(3), STEP_W'(4): begin
                    s_adl_d = 1'b1;
                    s_dec_d = 1'b1;
                    // RESET performs dummy pushes: S still walks, but nothing is written
                    if (kind_d != KIND_RESET) begin
                        rw_d     = 1'b0;
                        db_src_d = SRC_W'(step_d - STEP_W'(1));
                    end
                    if (step_d == STEP_T4) begin
                        set_i_d  = 1'b1;
                        push_b_d = (kind_d == KIND_BRK);
                    end
                end
                STEP_W'(5): begin
                    vec_addr_d = vec_base;
                    pcl_load_d = 1'b1;
                end
                STEP_W'(6): begin
                    vec_addr_d = vec_base | ADDR_W'(1);
                    pch_load_d = 1'b1;
                    done_d     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign SEQ_BUSY         = busy_q;
    assign SEQ_STEP         = step_q;
    assign SEQ_KIND         = kind_q;
    assign RW               = rw_q;
    assign S_ADL_BUS_ENABLE = s_adl_q;
    assign S_DEC            = s_dec_q;
    assign DB_SRC           = db_src_q;
    assign PUSH_B           = push_b_q;
    assign VEC_ADDR         = vec_addr_q;
    assign PCL_LOAD         = pcl_load_q;
    assign PCH_LOAD         = pch_load_q;
    assign SET_I            = set_i_q;
    assign DONE             = done_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed scenarios then random stimulus, every cycle
// compared against a cycle-level behavioural model of the service sequence.
module tb_int_sequencer;

    logic        CLK = 1'b0;
    logic        RES_N, RDY, INSTR_END, BRK_REQ, NMI_N, IRQ_N, I_FLAG;
    logic        SEQ_BUSY, RW, S_ADL_BUS_ENABLE, S_DEC, PUSH_B;
    logic [2:0]  SEQ_STEP;
    logic [1:0]  SEQ_KIND, DB_SRC;
    logic [15:0] VEC_ADDR;
    logic        PCL_LOAD, PCH_LOAD, SET_I, DONE;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit         m_busy;
    int         m_t;
    logic [1:0] m_kind;
    bit         m_reset_pend, m_nmi_pend, m_nmi_prev, m_after_done;

    int_sequencer dut (
        .CLK(CLK), .RES_N(RES_N), .RDY(RDY), .INSTR_END(INSTR_END), .BRK_REQ(BRK_REQ),
        .NMI_N(NMI_N), .IRQ_N(IRQ_N), .I_FLAG(I_FLAG),
        .SEQ_BUSY(SEQ_BUSY), .SEQ_STEP(SEQ_STEP), .SEQ_KIND(SEQ_KIND), .RW(RW),
        .S_ADL_BUS_ENABLE(S_ADL_BUS_ENABLE), .S_DEC(S_DEC), .DB_SRC(DB_SRC),
        .PUSH_B(PUSH_B), .VEC_ADDR(VEC_ADDR), .PCL_LOAD(PCL_LOAD), .PCH_LOAD(PCH_LOAD),
        .SET_I(SET_I), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_busy = 1'b0; m_t = 0; m_kind = 2'd0;
        m_reset_pend = 1'b1; m_nmi_pend = 1'b0; m_nmi_prev = 1'b1; m_after_done = 1'b0;
    endtask

    task automatic start_seq(input logic [1:0] k);
        m_busy = 1'b1; m_t = 0; m_kind = k;
        if (k == 2'd0) m_reset_pend = 1'b0;
    endtask

    // one rising edge of the sequence, using the inputs present at that edge
    task automatic model_edge();
        bit ne, clr, nmi_ok;
        if (!RES_N) return;
        ne = m_nmi_prev && !NMI_N;
        clr = 1'b0;
        if (RDY) begin
            if (!m_busy) begin
                nmi_ok = m_nmi_pend && (INSTR_END || m_after_done);
                m_after_done = 1'b0;
                if (m_reset_pend)                               start_seq(2'd0);
                else if (nmi_ok)                                start_seq(2'd1);
                else if (INSTR_END && BRK_REQ)                  start_seq(2'd2);
                else if (INSTR_END && !IRQ_N && !I_FLAG)        start_seq(2'd3);
            end else if (m_t == 6) begin
                m_busy = 1'b0; m_t = 0; m_after_done = 1'b1;
            end else begin
                if (m_t == 4 && (m_kind == 2'd1 || (m_kind >= 2'd2 && m_nmi_pend))) begin
                    m_kind = 2'd1;
                    clr = 1'b1;
                end
                m_t++;
            end
        end
        m_nmi_pend = (m_nmi_pend && !clr) || ne;
        m_nmi_prev = NMI_N;
    endtask

    function automatic logic [31:0] expected();
        bit         push, wr;
        logic [15:0] base, vec;
        logic [1:0]  db;
        push = m_busy && (m_t >= 2) && (m_t <= 4);
        wr   = push && (m_kind != 2'd0);
        db   = wr ? 2'(m_t - 1) : 2'd0;
        base = (m_kind == 2'd0) ? 16'hFFFC : (m_kind == 2'd1) ? 16'hFFFA : 16'hFFFE;
        vec  = (m_busy && m_t == 5) ? base : (m_busy && m_t == 6) ? base + 16'd1 : 16'd0;
        return {m_busy, (m_busy ? 3'(m_t) : 3'd0), m_kind, !wr, push, push, db,
                (m_busy && m_t == 4 && m_kind == 2'd2), vec,
                (m_busy && m_t == 5), (m_busy && m_t == 6), (m_busy && m_t == 4),
                (m_busy && m_t == 6)};
    endfunction

    task automatic check(input string tag);
        logic [31:0] act, exp;
        act = {SEQ_BUSY, SEQ_STEP, SEQ_KIND, RW, S_ADL_BUS_ENABLE, S_DEC, DB_SRC, PUSH_B,
               VEC_ADDR, PCL_LOAD, PCH_LOAD, SET_I, DONE};
        exp = expected();
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check(tag);
    endtask

    // advance until the model reaches the requested step (or idle); bounded
    task automatic run_until(input bit want_busy, input int want_t, input string tag);
        bit hit;
        hit = (m_busy == want_busy) && (!want_busy || m_t == want_t);
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(tag);
            hit = (m_busy == want_busy) && (!want_busy || m_t == want_t);
        end
        total++;
        assert (hit) else begin
            bad++;
            $error("FAIL %s_timeout: observed=0 expected=1 at %0t", tag, $time);
        end
    endtask

    initial begin
        RES_N = 1'b0; RDY = 1'b1; INSTR_END = 1'b0; BRK_REQ = 1'b0;
        NMI_N = 1'b1; IRQ_N = 1'b1; I_FLAG = 1'b0;
        model_reset();
        tick("in_reset");
        tick("in_reset");
        check_val("reset_rw", 16'(RW), 16'd1);

        // release: RESET sequence from the first edge
        RES_N = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick("reset_seq");
            if (i == 2) check_val("reset_t2_rw_sdec", {14'd0, RW, S_DEC}, 16'd3);
            if (i == 5) check_val("reset_vec_lo", VEC_ADDR, 16'hFFFC);
        end
        check_val("reset_done_vec", {DONE, VEC_ADDR[14:0]}, {1'b1, 15'h7FFD});
        tick("idle");
        tick("idle");

        // IRQ taken at an instruction boundary
        IRQ_N = 1'b0; INSTR_END = 1'b1;
        tick("irq_start");
        INSTR_END = 1'b0; IRQ_N = 1'b1;
        run_until(1'b1, 5, "irq_run");
        check_val("irq_vec_lo", VEC_ADDR, 16'hFFFE);
        run_until(1'b0, 0, "irq_end");
        tick("idle");

        // IRQ masked by I flag
        IRQ_N = 1'b0; I_FLAG = 1'b1; INSTR_END = 1'b1;
        repeat (3) tick("irq_masked");
        check_val("irq_masked_busy", 16'(SEQ_BUSY), 16'd0);
        IRQ_N = 1'b1; I_FLAG = 1'b0; INSTR_END = 1'b0;

        // BRK outranks IRQ
        BRK_REQ = 1'b1; IRQ_N = 1'b0; INSTR_END = 1'b1;
        tick("brk_start");
        BRK_REQ = 1'b0; IRQ_N = 1'b1; INSTR_END = 1'b0;
        check_val("brk_kind", 16'(SEQ_KIND), 16'd2);
        run_until(1'b1, 4, "brk_run");
        check_val("brk_push_b", 16'(PUSH_B), 16'd1);
        run_until(1'b0, 0, "brk_end");
        tick("idle");

        // BRK hijacked by an NMI edge during T3
        BRK_REQ = 1'b1; INSTR_END = 1'b1;
        tick("hij_start");
        BRK_REQ = 1'b0; INSTR_END = 1'b0;
        run_until(1'b1, 3, "hij_t3");
        NMI_N = 1'b0;
        run_until(1'b1, 5, "hij_t5");
        check_val("hij_vec", VEC_ADDR, 16'hFFFA);
        check_val("hij_kind", 16'(SEQ_KIND), 16'd1);
        run_until(1'b0, 0, "hij_end");
        INSTR_END = 1'b1;
        repeat (4) tick("hij_no_second");
        check_val("hij_no_second_busy", 16'(SEQ_BUSY), 16'd0);
        INSTR_END = 1'b0; NMI_N = 1'b1;
        tick("idle");

        // RDY low for three cycles in T2
        IRQ_N = 1'b0; INSTR_END = 1'b1;
        tick("rdy_start");
        IRQ_N = 1'b1; INSTR_END = 1'b0;
        run_until(1'b1, 2, "rdy_t2");
        RDY = 1'b0;
        repeat (3) tick("rdy_hold");
        check_val("rdy_hold_step", {13'd0, SEQ_STEP}, 16'd2);
        RDY = 1'b1;
        run_until(1'b0, 0, "rdy_end");
        tick("idle");

        // async reset during T4 of IRQ, then full RESET sequence
        IRQ_N = 1'b0; INSTR_END = 1'b1;
        tick("abort_start");
        IRQ_N = 1'b1; INSTR_END = 1'b0;
        run_until(1'b1, 4, "abort_t4");
        RES_N = 1'b0;
        #1;
        model_reset();
        check("abort_async");
        check_val("abort_busy", 16'(SEQ_BUSY), 16'd0);
        tick("abort_held");
        RES_N = 1'b1;
        run_until(1'b1, 5, "abort_reset_t5");
        check_val("abort_reset_vec", VEC_ADDR, 16'hFFFC);
        run_until(1'b0, 0, "abort_reset_end");

        // NMI edge after the vector fetch starts is serviced right after DONE
        NMI_N = 1'b0;
        tick("nmi_edge");
        INSTR_END = 1'b1;
        tick("nmi_start");
        INSTR_END = 1'b0; NMI_N = 1'b1;
        run_until(1'b1, 5, "nmi_t5");
        NMI_N = 1'b0;
        run_until(1'b0, 0, "nmi_end");
        tick("nmi_again");
        check_val("nmi_again_busy_kind", {13'd0, SEQ_BUSY, SEQ_KIND}, 16'h0005);
        run_until(1'b0, 0, "nmi_again_end");
        NMI_N = 1'b1;

        // random stimulus
        for (int i = 0; i < 4000; i++) begin
            RDY       = ($urandom_range(0, 7) != 0);
            INSTR_END = ($urandom_range(0, 2) == 0);
            BRK_REQ   = ($urandom_range(0, 7) == 0);
            IRQ_N     = ($urandom_range(0, 2) != 0);
            I_FLAG    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) NMI_N = ~NMI_N;
            if (!RES_N) RES_N = 1'b1;
            else if ($urandom_range(0, 299) == 0) begin
                RES_N = 1'b0;
                #1;
                model_reset();
                check("rand_reset");
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
